mont_exp_ctrl: RTL and testbench

- Square-and-multiply sequencer for modular exponentiation; sits directly upstream of the 256-bit Montgomery multiplier and drives its A/B/N/n_start inputs, consuming S/n_ready.
- Computes result = base^exponent mod N from Montgomery-form operands supplied by the host: base_m = base·R mod N and one_m = R mod N, with R = 2^W.
- Final multiply by 1 converts the accumulator out of the Montgomery domain.

---
 rtl/mont_pkg.sv | 26 ++
 rtl/mont_exp_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mont_exp_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared types and constants for the Montgomery exponentiation sequencer.
package mont_pkg;

  // Default operand/modulus width; must match the Montgomery multiplier.
  localparam int W_DEF = 256;

  // Sequencer states. Every *_ISSUE state lasts exactly one cycle.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SQ_ISSUE  = 3'd1,
    S_SQ_WAIT   = 3'd2,
    S_MUL_ISSUE = 3'd3,
    S_MUL_WAIT  = 3'd4,
    S_OUT_ISSUE = 3'd5,
    S_OUT_WAIT  = 3'd6,
    S_DONE      = 3'd7
  } state_e;

  // The multiplier handshake is active-low in both directions.
  localparam logic MM_START_ACTIVE = 1'b0;
  localparam logic MM_READY_ACTIVE = 1'b0;

  // Multiplying by plain 1 strips the R factor and leaves the Montgomery domain.
  localparam logic [W_DEF-1:0] ONE_W = {{(W_DEF-1){1'b0}}, 1'b1};

endpackage : mont_pkg

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a Montgomery multiplier.
// The multiplier does all arithmetic; this block only routes operands, walks
// the exponent bits and handles the start/ready handshake.
module mont_exp_ctrl
  import mont_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int EW      = 256,
  parameter int HOLDOFF = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  base_m,
  input  logic [W-1:0]  one_m,
  input  logic [W-1:0]  modulus,
  input  logic [EW-1:0] exponent,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [W-1:0]  mm_a,
  output logic [W-1:0]  mm_b,
  output logic [W-1:0]  mm_n,
  output logic          mm_n_start,
  input  logic [W-1:0]  mm_s,
  input  logic          mm_n_ready
);

  localparam int IW = (EW > 1) ? $clog2(EW) : 1;
  localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [W-1:0] ONE_OP = W'(ONE_W);

  state_e         state_q, state_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   base_q, base_d;
  logic [W-1:0]   mod_q, mod_d;
  logic [EW-1:0]  exp_q, exp_d;
  logic [W-1:0]   result_q, result_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [HW-1:0]  hold_q, hold_d;

  // A result is taken only once the holdoff has expired, so a ready level left
  // over from the previous operation is never mistaken for the new result.
  logic mm_take;
  assign mm_take = (hold_q == '0) && (mm_n_ready == MM_READY_ACTIVE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers: accumulator, latched operands, bit index, holdoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      base_q   <= '0;
      mod_q    <= '0;
      exp_q    <= '0;
      result_q <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      base_q   <= base_d;
      mod_q    <= mod_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    // NOTE: every variable gets a hold-value default first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d  = state_q;
    acc_d    = acc_q;
    base_d   = base_q;
    mod_d    = mod_q;
    exp_d    = exp_q;
    result_d = result_q;
    idx_d    = idx_q;
    hold_d   = hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_m;
          mod_d   = modulus;
          exp_d   = exponent;
          acc_d   = one_m;
          idx_d   = IW'(EW - 1);
          state_d = S_SQ_ISSUE;
        end
      end

      S_SQ_ISSUE: begin
        hold_d  = HW'(HOLDOFF);
        state_d = S_SQ_WAIT;
      end

      S_MUL_ISSUE: begin
        hold_d  = HW'(HOLDOFF);
        state_d = S_MUL_WAIT;
      end

      S_OUT_ISSUE: begin
        hold_d  = HW'(HOLDOFF);
        state_d = S_OUT_WAIT;
      end

      S_SQ_WAIT: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (mm_take) begin
          acc_d = mm_s;
          if (exp_q[idx_q])       state_d = S_MUL_ISSUE;
          else if (idx_q == '0)   state_d = S_OUT_ISSUE;
          else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_SQ_ISSUE;
          end
        end
      end

      S_MUL_WAIT: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (mm_take) begin
          acc_d = mm_s;
          if (idx_q == '0) state_d = S_OUT_ISSUE;
          else begin
            idx_d   = idx_q - 1'b1;
            state_d = S_SQ_ISSUE;
          end
        end
      end

      S_OUT_WAIT: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else if (mm_take) begin
          result_d = mm_s;
          state_d  = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Multiplier operands and handshake, decoded from the registered state so
  // they stay constant from ISSUE through the end of the matching WAIT.
  always_comb begin
    mm_a       = '0;
    mm_b       = '0;
    mm_n_start = ~MM_START_ACTIVE;
    case (state_q)
      S_SQ_ISSUE, S_SQ_WAIT: begin
        mm_a = acc_q;
        mm_b = acc_q;
      end
      S_MUL_ISSUE, S_MUL_WAIT: begin
        mm_a = acc_q;
        mm_b = base_q;
      end
      S_OUT_ISSUE, S_OUT_WAIT: begin
        mm_a = acc_q;
        mm_b = ONE_OP;
      end
      default: ;
    endcase
    if (state_q inside {S_SQ_ISSUE, S_MUL_ISSUE, S_OUT_ISSUE})
      mm_n_start = MM_START_ACTIVE;
  end

  assign busy   = !(state_q inside {S_IDLE, S_DONE});
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign mm_n   = mod_q;

endmodule : mont_exp_ctrl

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl with a behavioural Montgomery multiplier
// (N=13, R=2^256, R mod 13 = 3, R^-1 mod 13 = 9) and a result scoreboard.
module tb_mont_exp_ctrl;
  import mont_pkg::*;

  localparam int W  = 256;
  localparam int EW = 8;
  localparam logic [W-1:0] N_VAL  = 256'd13;
  localparam logic [W-1:0] ONE_M  = 256'd3;
  localparam logic [W-1:0] BASE_M = 256'd12;  // 4 * 3 mod 13

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  base_m, one_m, modulus;
  logic [EW-1:0] exponent;
  logic          busy, done;
  logic [W-1:0]  result, mm_a, mm_b, mm_n, mm_s;
  logic          mm_n_start, mm_n_ready;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.W(W), .EW(EW), .HOLDOFF(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_m     (base_m),
    .one_m      (one_m),
    .modulus    (modulus),
    .exponent   (exponent),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .mm_a       (mm_a),
    .mm_b       (mm_b),
    .mm_n       (mm_n),
    .mm_n_start (mm_n_start),
    .mm_s       (mm_s),
    .mm_n_ready (mm_n_ready)
  );

  typedef struct {
    logic [W-1:0] res;
    int           starts;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   lat = 1;
  int   mm_starts = 0;
  int   start_base = 0;
  int   stab_err = 0;
  int   stab_base = 0;

  // Multiplier model state.
  logic         rise_pend;
  int           cnt;
  logic [W-1:0] s_pend, a_lat, b_lat, n_lat;

  function automatic logic [W-1:0] mm_model(input logic [W-1:0] a, b, n);
    if (n !== N_VAL) return 256'hDEAD;
    return ((a % N_VAL) * (b % N_VAL) * 256'd9) % N_VAL;
  endfunction

  // Behavioural multiplier: ready stays low (stale) for one cycle after the
  // start pulse, then goes high for lat cycles, then drops with the new S.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mm_n_ready <= 1'b0;
      mm_s       <= '0;
      rise_pend  <= 1'b0;
      cnt        <= 0;
      s_pend     <= '0;
    end else begin
      if (mm_n_start == 1'b0) begin
        mm_starts <= mm_starts + 1;
        s_pend    <= mm_model(mm_a, mm_b, mm_n);
        a_lat     <= mm_a;
        b_lat     <= mm_b;
        n_lat     <= mm_n;
        rise_pend <= 1'b1;
      end else if (rise_pend) begin
        rise_pend  <= 1'b0;
        mm_n_ready <= 1'b1;
        cnt        <= lat;
      end else if (mm_n_ready) begin
        if (cnt <= 1) begin
          mm_n_ready <= 1'b0;
          mm_s       <= s_pend;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  // Operand stability while the multiplier is working.
  always @(negedge clk) begin
    if (!rst && (rise_pend || mm_n_ready)) begin
      if (mm_a !== a_lat || mm_b !== b_lat || mm_n !== n_lat) stab_err++;
    end
  end

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Drive a one-cycle start with the standard operands; optionally record the
  // expected result and multiplier start count in the scoreboard.
  task automatic drive_start(input logic [EW-1:0] e, input int l, input bit push);
    exp_t x;
    int   r;
    lat      = l;
    exponent = e;
    base_m   = BASE_M;
    one_m    = ONE_M;
    modulus  = N_VAL;
    if (push) begin
      r = 1;
      for (int i = 0; i < int'(e); i++) r = (r * 4) % 13;
      x.res    = W'(r);
      x.starts = EW + $countones(e) + 1;
      sb_q.push_back(x);
    end
    start_base = mm_starts;
    stab_base  = stab_err;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", W'(busy), W'(1));
  endtask

  // Wait (bounded) for done, then compare against the scoreboard head.
  task automatic wait_done(input string tag, input int budget, input bit chk_hold,
                           input logic [W-1:0] held);
    bit   seen = 1'b0;
    int   hold_err = 0;
    exp_t x;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (chk_hold && result !== held) hold_err++;
    end
    check({tag, "_done_seen"}, W'(seen), W'(1));
    if (!seen) return;
    check({tag, "_sb_nonempty"}, W'(sb_q.size() != 0), W'(1));
    if (sb_q.size() == 0) return;
    x = sb_q.pop_front();
    check({tag, "_result"}, result, x.res);
    check({tag, "_mm_starts"}, W'(mm_starts - start_base), W'(x.starts));
    check({tag, "_busy_at_done"}, W'(busy), W'(0));
    check({tag, "_operands_stable"}, W'(stab_err - stab_base), W'(0));
    if (chk_hold) check({tag, "_result_held"}, W'(hold_err), W'(0));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, W'(done), W'(0));
    check({tag, "_result_after"}, result, x.res);
  endtask

  initial begin
    bit reached;
    rst      = 1'b1;
    start    = 1'b0;
    base_m   = '0;
    one_m    = '0;
    modulus  = '0;
    exponent = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_result", result, '0);
    check("rst_mm_a", mm_a, '0);
    check("rst_mm_b", mm_b, '0);
    check("rst_mm_n", mm_n, '0);
    check("rst_mm_n_start", W'(mm_n_start), W'(1));
    rst = 1'b0;
    @(negedge clk);

    // exponent 5, latency 3: 4^5 mod 13 = 10, 11 starts.
    drive_start(8'd5, 3, 1'b1);
    wait_done("e5_l3", 4000, 1'b0, '0);

    // exponent 0 and 12 at latency 1: both give 1; holdoff masks stale ready.
    drive_start(8'd0, 1, 1'b1);
    wait_done("e0_l1", 4000, 1'b0, '0);
    drive_start(8'd12, 1, 1'b1);
    wait_done("e12_l1", 4000, 1'b0, '0);

    // exponent 1, latency 300, with stray starts and input changes mid-run.
    drive_start(8'd1, 300, 1'b1);
    repeat (40) @(negedge clk);
    start    = 1'b1;
    exponent = 8'd0;
    base_m   = 256'd7;
    one_m    = 256'd5;
    modulus  = 256'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (700) @(negedge clk);
    start    = 1'b1;
    exponent = 8'd255;
    @(negedge clk);
    start = 1'b0;
    wait_done("e1_l300", 20000, 1'b0, '0);

    // Abort with reset while the first MUL is outstanding.
    drive_start(8'd255, 3, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mm_starts - start_base >= 2) begin
        reached = 1'b1;
        break;
      end
    end
    check("abort_reached_mul", W'(reached), W'(1));
    #1 rst = 1'b1;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_result", result, '0);
    check("abort_mm_a", mm_a, '0);
    check("abort_mm_b", mm_b, '0);
    check("abort_mm_n", mm_n, '0);
    check("abort_mm_n_start", W'(mm_n_start), W'(1));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mm_n_start_next_edge", W'(mm_n_start), W'(1));
    check("abort_busy_next_edge", W'(busy), W'(0));
    @(negedge clk);

    // Restart after abort, then a back-to-back run started the cycle after done.
    drive_start(8'd5, 2, 1'b1);
    wait_done("e5_after_abort", 4000, 1'b0, '0);
    drive_start(8'd3, 2, 1'b1);
    wait_done("e3_back_to_back", 4000, 1'b1, 256'd10);

    check("sb_drained", W'(sb_q.size()), W'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mont_exp_ctrl
